// File: rtl/dual_edge_rstb_capture.sv
`default_nettype none
`timescale 1ns/1fs
// +--------------------------------------------------------------------------+
// | Module   : dual_edge_rstb_capture                                        |
// | Desc     : Dual-edge capture cell, async active-low reset, phase mux.    |
// |            Optional clock buffer stage: DUAL_EDGE_CAPTURE_CLKBUF_EN.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dual_edge_rstb_capture #(
   parameter int               WIDTH        = 1,
   parameter logic [WIDTH-1:0] RST_VAL      = '0,
   parameter int               BUF_DELAY_PS = 0
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_pos,
   output logic [WIDTH-1:0] q_neg,
   output logic [WIDTH-1:0] q
);

   logic w_clk_buf;

`ifdef DUAL_EDGE_CAPTURE_CLKBUF_EN
   // Behavioural buffer delay; synthesis maps this to a plain buffer cell.
   assign #(BUF_DELAY_PS * 1ps) w_clk_buf = clk;
`else
   logic w_unused_buf_delay;
   assign w_unused_buf_delay = (BUF_DELAY_PS != 0);
   assign w_clk_buf          = clk;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic r_pos;
      logic r_neg;

      always_ff @(posedge w_clk_buf or negedge rstb) begin
         if (!rstb) begin
            r_pos <= RST_VAL[i];
         end else begin
            r_pos <= d[i];
         end
      end

      always_ff @(negedge w_clk_buf or negedge rstb) begin
         if (!rstb) begin
            r_neg <= RST_VAL[i];
         end else begin
            r_neg <= d[i];
         end
      end

      assign q_pos[i] = r_pos;
      assign q_neg[i] = r_neg;
      // Select on raw clk; an X select merges the banks bitwise (X only where they differ).
      assign q[i]     = clk ? r_pos : r_neg;
   end

endmodule
`default_nettype wire

// File: tb/tb_dual_edge_rstb_capture.sv
`default_nettype none
`timescale 1ns/1fs
// +--------------------------------------------------------------------------+
// | Module   : tb_dual_edge_rstb_capture                                     |
// | Desc     : Directed self-checking bench for dual_edge_rstb_capture.      |
// |            Honours DUAL_EDGE_CAPTURE_CLKBUF_EN for the buffer-delay case.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dual_edge_rstb_capture;

   localparam realtime c_HALF = 195.3125;

   logic       clk;
   logic       rstb;
   logic [0:0] d;
   logic [0:0] q_pos;
   logic [0:0] q_neg;
   logic [0:0] q;

   int r_checks = 0;
   int r_errors = 0;

   logic r_exp_pos;
   logic r_exp_neg;

   dual_edge_rstb_capture #(
      .WIDTH        (1),
      .RST_VAL      (1'b0),
      .BUF_DELAY_PS (100)
   ) u_dut (
      .clk   (clk),
      .rstb  (rstb),
      .d     (d),
      .q_pos (q_pos),
      .q_neg (q_neg),
      .q     (q)
   );

   initial clk = 1'b0;
   always #(c_HALF) clk = ~clk;

   task automatic check_value(input string tag, input logic observed, input logic expected);
      r_checks++;
      if (observed !== expected) begin
         r_errors++;
         $display("FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_pos, input logic e_neg, input logic e_q);
      check_value({tag, ".q_pos"}, q_pos[0], e_pos);
      check_value({tag, ".q_neg"}, q_neg[0], e_neg);
      check_value({tag, ".q"},     q[0],     e_q);
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstb = 1'b0;
      d    = 1'b1;

      // 1. Reset hold across three clock periods.
      #1;
      check_all("rst_hold_t0", 1'b0, 1'b0, 1'b0);
      repeat (6) begin
         @(clk);
         #10;
         check_all("rst_hold", 1'b0, 1'b0, 1'b0);
      end

      // 2. Release while clk low; first capture on the posedge.
      @(negedge clk);
      #50;
      rstb = 1'b1;
      #1;
      check_all("rel_low_no_capture", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #10;
      check_all("rel_low_first_pos", 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      #10;
      check_all("rel_low_first_neg", 1'b1, 1'b1, 1'b1);
      repeat (4) begin
         @(clk);
         #10;
         check_value("rel_low_steady.q", q[0], 1'b1);
      end

      // 3. Release while clk high; first capture on the negedge.
      @(posedge clk);
      #20;
      rstb = 1'b0;
      #20;
      check_all("rst_in_high", 1'b0, 1'b0, 1'b0);
      #20;
      rstb = 1'b1;
      #10;
      check_all("rel_high_no_capture", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #10;
      check_all("rel_high_first_neg", 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #10;
      check_all("rel_high_first_pos", 1'b1, 1'b1, 1'b1);

      // 4. 10 ns reset pulse mid-run with clk high.
      #20;
      check_all("pulse_before", 1'b1, 1'b1, 1'b1);
      rstb = 1'b0;
      #1;
      check_all("pulse_during", 1'b0, 1'b0, 1'b0);
      #9;
      rstb = 1'b1;
      #1;
      check_all("pulse_after_release", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #10;
      check_all("pulse_recap_neg", 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #10;
      check_all("pulse_recap_pos", 1'b1, 1'b1, 1'b1);

      // 5. d toggled once per clock, mid-high-phase, so the banks disagree while clk is low.
      r_exp_pos = q_pos[0];
      for (int k = 0; k < 6; k++) begin
         #(c_HALF / 2 - 10);
         d = ~d;
         @(negedge clk);
         r_exp_neg = d[0];
         #10;
         check_all("tog_low", r_exp_pos, r_exp_neg, r_exp_neg);
         @(posedge clk);
         r_exp_pos = d[0];
         #10;
         check_all("tog_high", r_exp_pos, r_exp_neg, r_exp_pos);
      end

      // 6. Capture timing relative to raw clk edges.
      @(negedge clk);
      #50;
      r_exp_neg = q_neg[0];
      r_exp_pos = q_pos[0];
      d = ~q_pos;
      @(posedge clk);
      #0.05;
      check_value("edge_mux_raw.q_sel", q[0], q_pos[0]);
`ifdef DUAL_EDGE_CAPTURE_CLKBUF_EN
      check_value("buf_before_delay.q_pos", q_pos[0], r_exp_pos);
      #0.1;
      check_value("buf_after_delay.q_pos", q_pos[0], ~r_exp_pos);
`else
      check_value("nobuf_aligned.q_pos", q_pos[0], ~r_exp_pos);
`endif
      check_value("edge_neg_frozen.q_neg", q_neg[0], r_exp_neg);

      $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
      $finish;
   end

endmodule
`default_nettype wire
